// File: rtl/adc_acq_ctrl.sv
// -----------------------------------------------------------------------------
// adc_acq_ctrl
//
// Acquisition controller for a pipelined parallel-output ADC (AD9220 class).
// A rising edge of the synchronised Hold strobe, qualified by StartAcq, starts
// an acquisition: after AdcStartDelay Clk cycles a divided ADC_CLK is produced,
// the first PIPE_LAT captures (converter pipeline latency) are thrown away, and
// the remaining captures are streamed as 16-bit words, either raw or as
// power-of-two block averages. The acquisition ends when AdcDataNumber words
// have been emitted or when the synchronised Hold goes low.
//
// Build option:
//   ADC_AVERAGE_EN - when defined, the accumulator and AvgShift averaging are
//                    compiled in. When undefined, AvgShift is ignored and every
//                    kept capture is emitted as a raw word.
//
// Ports:
//   Clk            system clock
//   reset_n        asynchronous active-low reset
//   Hold           asynchronous hold strobe (2-flop synchronised here)
//   StartAcq       qualifies the Hold rising edge
//   AdcStartDelay  Clk cycles from detected Hold edge to ADC start
//   AdcDataNumber  output words per acquisition (0 = no conversion at all)
//   AvgShift       2^AvgShift captures per output word (0 = raw)
//   ADC_DATA       converter parallel output
//   ADC_OTR        converter out-of-range flag
//   ADC_CLK        generated converter clock
//   Data           {zero pad, OTR, sample/average}
//   Data_en        one-cycle strobe qualifying Data
//   Busy           high whenever the controller is not idle
//   Done           one-cycle pulse at the end of an acquisition
// -----------------------------------------------------------------------------
module adc_acq_ctrl #(
  parameter int ADC_WIDTH   = 12,
  parameter int CLK_DIV     = 4,
  parameter int PIPE_LAT    = 3,
  parameter int DELAY_WIDTH = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic                   Hold,
  input  logic                   StartAcq,
  input  logic [DELAY_WIDTH-1:0] AdcStartDelay,
  input  logic [CNT_WIDTH-1:0]   AdcDataNumber,
  input  logic [2:0]             AvgShift,
  input  logic [ADC_WIDTH-1:0]   ADC_DATA,
  input  logic                   ADC_OTR,
  output logic                   ADC_CLK,
  output logic [15:0]            Data,
  output logic                   Data_en,
  output logic                   Busy,
  output logic                   Done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  // Sized so that the value PIPE_LAT itself is representable, even for 0.
  localparam int PL_W  = $clog2(PIPE_LAT + 2);
  // Enough headroom for 2^7 full-scale captures.
  localparam int ACC_W = ADC_WIDTH + 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic                   holdMeta;
  logic                   holdSync;
  logic                   holdRising;

  logic [DELAY_WIDTH-1:0] delayR;
  logic [DELAY_WIDTH-1:0] delayCnt;
  logic [CNT_WIDTH-1:0]   numR;
  logic [CNT_WIDTH-1:0]   wordCnt;
  logic [DIV_W-1:0]       divCnt;
  logic [DIV_W-1:0]       divNext;
  logic [PL_W-1:0]        discardCnt;
  logic                   clkRun;
  logic                   wordDone;
  logic                   capValid;
  logic [ADC_WIDTH-1:0]   capData;
  logic                   capOtr;

  logic                   delayLast;
  logic                   capUse;
  logic                   emit;
  logic                   wordHit;
  logic [ADC_WIDTH-1:0]   wordVal;
  logic                   wordOtr;

`ifdef ADC_AVERAGE_EN
  logic [2:0]             shiftR;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       accSum;
  logic [7:0]             grpCnt;
  logic [7:0]             grpNext;
  logic                   otrAcc;
`else
  logic                   unusedAvgShift;
  assign unusedAvgShift = ^AvgShift;
`endif

  // Builds the 16-bit output word: sample in the low bits, OTR just above it.
  function automatic logic [15:0] packWord(input logic otr, input logic [ADC_WIDTH-1:0] val);
    logic [15:0] w;
    w                  = 16'h0000;
    w[ADC_WIDTH]       = otr;
    w[ADC_WIDTH-1:0]   = val;
    return w;
  endfunction

  // Two-flop synchroniser for the asynchronous Hold strobe.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      holdMeta <= 1'b0;
      holdSync <= 1'b0;
    end else begin
      holdMeta <= Hold;
      holdSync <= holdMeta;
    end
  end

  // The rising edge is taken one stage early so DELAY is entered on the
  // second edge that sees Hold high.
  assign holdRising = holdMeta & ~holdSync;

  // Next-state helpers: divider step, delay end, capture use and word emission.
  always_comb begin
    divNext   = (divCnt == DIV_W'(CLK_DIV - 1)) ? {DIV_W{1'b0}} : (divCnt + DIV_W'(1));
    delayLast = (delayR == {DELAY_WIDTH{1'b0}}) || (delayCnt == (delayR - DELAY_WIDTH'(1)));
    capUse    = capValid && (discardCnt == PL_W'(PIPE_LAT));
`ifdef ADC_AVERAGE_EN
    accSum    = acc + ACC_W'(capData);
    grpNext   = grpCnt + 8'd1;
    // Truncating shift; the sum of 2^shift samples always fits ADC_WIDTH after it.
    wordVal   = ADC_WIDTH'(accSum >> shiftR);
    wordOtr   = otrAcc | capOtr;
    emit      = capUse && (grpNext == (8'd1 << shiftR));
`else
    wordVal   = capData;
    wordOtr   = capOtr;
    emit      = capUse;
`endif
    wordHit   = emit && ((wordCnt + CNT_WIDTH'(1)) == numR);
  end

  // Main FSM with registered outputs, divider, capture and word assembly.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ADC_CLK    <= 1'b0;
      Data       <= 16'h0000;
      Data_en    <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      delayR     <= {DELAY_WIDTH{1'b0}};
      delayCnt   <= {DELAY_WIDTH{1'b0}};
      numR       <= {CNT_WIDTH{1'b0}};
      wordCnt    <= {CNT_WIDTH{1'b0}};
      divCnt     <= {DIV_W{1'b0}};
      discardCnt <= {PL_W{1'b0}};
      clkRun     <= 1'b0;
      wordDone   <= 1'b0;
      capValid   <= 1'b0;
      capData    <= {ADC_WIDTH{1'b0}};
      capOtr     <= 1'b0;
`ifdef ADC_AVERAGE_EN
      shiftR     <= 3'd0;
      acc        <= {ACC_W{1'b0}};
      grpCnt     <= 8'd0;
      otrAcc     <= 1'b0;
`endif
    end else begin
      Data_en  <= 1'b0;
      Done     <= 1'b0;
      capValid <= 1'b0;

      case (state)
        IDLE: begin
          Busy    <= 1'b0;
          ADC_CLK <= 1'b0;
          if (holdRising && StartAcq) begin
            state      <= DELAY;
            Busy       <= 1'b1;
            delayR     <= AdcStartDelay;
            numR       <= AdcDataNumber;
            delayCnt   <= {DELAY_WIDTH{1'b0}};
            wordCnt    <= {CNT_WIDTH{1'b0}};
            discardCnt <= {PL_W{1'b0}};
            wordDone   <= 1'b0;
            clkRun     <= 1'b0;
`ifdef ADC_AVERAGE_EN
            shiftR     <= AvgShift;
            acc        <= {ACC_W{1'b0}};
            grpCnt     <= 8'd0;
            otrAcc     <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end

        DELAY: begin
          if (delayLast) begin
            if (numR == {CNT_WIDTH{1'b0}}) begin
              // Nothing to convert: finish without ever toggling ADC_CLK.
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              state   <= RUN;
              divCnt  <= {DIV_W{1'b0}};
              ADC_CLK <= 1'b1;
              clkRun  <= 1'b1;
            end
          end else begin
            delayCnt <= delayCnt + DELAY_WIDTH'(1);
          end
        end

        RUN: begin
          // Consume the capture registered on the previous edge.
          if (capValid && !capUse) begin
            discardCnt <= discardCnt + PL_W'(1);
          end else if (emit) begin
            Data    <= packWord(wordOtr, wordVal);
            Data_en <= 1'b1;
            wordCnt <= wordCnt + CNT_WIDTH'(1);
`ifdef ADC_AVERAGE_EN
            acc     <= {ACC_W{1'b0}};
            grpCnt  <= 8'd0;
            otrAcc  <= 1'b0;
          end else if (capUse) begin
            acc     <= accSum;
            grpCnt  <= grpNext;
            otrAcc  <= wordOtr;
`endif
          end else begin
            wordCnt <= wordCnt;
          end

          if (wordDone || !holdSync) begin
            // Exit: any partial average is dropped and the converter clock stops.
            state   <= DONE;
            Done    <= 1'b1;
            ADC_CLK <= 1'b0;
            clkRun  <= 1'b0;
`ifdef ADC_AVERAGE_EN
            acc     <= {ACC_W{1'b0}};
            grpCnt  <= 8'd0;
            otrAcc  <= 1'b0;
`endif
          end else if (wordHit) begin
            // Last word goes out now; hold ADC_CLK low while the exit is taken.
            wordDone <= 1'b1;
            clkRun   <= 1'b0;
            ADC_CLK  <= 1'b0;
          end else if (clkRun) begin
            divCnt  <= divNext;
            ADC_CLK <= (divNext < DIV_W'(CLK_DIV / 2));
            // Sample one Clk before the ADC_CLK rising edge so the ADC output
            // delay has a whole Clk period to settle.
            if (divNext == DIV_W'(CLK_DIV - 1)) begin
              capValid <= 1'b1;
              capData  <= ADC_DATA;
              capOtr   <= ADC_OTR;
            end else begin
              capValid <= 1'b0;
            end
          end else begin
            ADC_CLK <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          Busy    <= 1'b0;
          ADC_CLK <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/adc_acq_ctrl.md
# adc_acq_ctrl

Parametrised acquisition controller for a pipelined parallel-output ADC (AD9220 class) in the SDHCAL_DAQ readout path. On a qualified rising edge of Hold, it waits a programmable delay and generates a divided ADC_CLK. It discards the converter's pipeline-latency samples, then streams either raw samples or power-of-two block averages as 16-bit words into the DAQ data FIFO path. Acquisition ends on a word count or when Hold falls.

## Interface
- ADC_WIDTH, 12, ADC sample width; ADC_WIDTH+1 ≤ 16
- CLK_DIV, 4, Clk cycles per ADC_CLK period; even, ≥ 2
- PIPE_LAT, 3, ADC pipeline latency in ADC_CLK periods; captures discarded after start
- DELAY_WIDTH, 4, width of AdcStartDelay
- CNT_WIDTH, 8, width of AdcDataNumber and the word counter
- Clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- Hold  in  1  hold strobe from ASIC path, asynchronous, 2-flop synchronised
- StartAcq  in  1  acquisition enable; qualifies Hold rising edge only
- AdcStartDelay  in  DELAY_WIDTH  Clk cycles between detected Hold edge and ADC start
- AdcDataNumber  in  CNT_WIDTH  output words per acquisition
- AvgShift  in  3  averaging mode: 2^AvgShift captures per output word (0 = raw)
- ADC_DATA  in  ADC_WIDTH  ADC parallel output
- ADC_OTR  in  1  ADC out-of-range flag
- ADC_CLK  out  1  generated ADC clock
- Data  out  16  {zero pad, OTR flag, sample/average}
- Data_en  out  1  one-cycle valid strobe for Data
- Busy  out  1  high in every state other than IDLE
- Done  out  1  one-cycle pulse at acquisition end

## Operation
- Reset values: ADC_CLK=0, Data=0, Data_en=0, Busy=0, Done=0. State is IDLE and all counters and the accumulator are cleared.
- Reset asserted mid-operation aborts immediately. No Done pulse is issued.
- States:
  - IDLE:
    - HoldRising && StartAcq -> DELAY.
    - HoldRising && !StartAcq -> stays in IDLE.
  - DELAY: counts AdcStartDelay cycles, then -> RUN. A delay of 0 goes to RUN on the next edge.
    - If AdcDataNumber==0, goes to DONE instead; no ADC_CLK, no Data_en.
  - RUN: the divider counter runs from 0 to CLK_DIV-1.
    - ADC_CLK is high for counts 0..CLK_DIV/2-1.
    - A capture strobe fires at count CLK_DIV-1. ADC_DATA and ADC_OTR are registered on that edge.
    - The first PIPE_LAT captures are discarded.
  - DONE: Done=1 for one cycle, then -> IDLE.
- Leaving RUN (to DONE):
  - the word count reaches AdcDataNumber, or
  - the synchronised Hold is low at any cycle.
  - Any partial average is discarded. ADC_CLK goes to 0 on the same edge.
- Raw mode (AvgShift=0): every valid capture produces one word.
- Average mode:
  - Accumulator width is ADC_WIDTH+7. It sums 2^AvgShift captures.
  - The output is sum >> AvgShift, truncated, not rounded.
  - The OTR flag is the OR of ADC_OTR over the group.
  - The accumulator clears after each word.
- Data layout: bits [ADC_WIDTH-1:0] hold the sample, bit ADC_WIDTH holds OTR, upper bits are 0. Data holds its value between strobes.
- Simultaneous events:
  - Hold falling on the same edge as the final word: the word is still emitted, then DONE.
  - A Hold rising edge outside IDLE is ignored.

## Timing
- Edge 1 is the first Clk edge that samples Hold=1. The FSM enters DELAY on edge 2.
- RUN entry is at edge E = 2 + AdcStartDelay.
- Capture n occurs at E + (CLK_DIV-1) + n·CLK_DIV.
- Data_en is registered one Clk after the last capture of its group.
- First raw word: E + (PIPE_LAT+1)·CLK_DIV; with defaults, E+16.
- Raw word spacing is CLK_DIV. Average word spacing is CLK_DIV·2^AvgShift.
- Done occurs one cycle after the exit condition; Busy falls with Done.
- ADC output delay (≤8 ns) must fit within one Clk. Capture at count CLK_DIV-1 guarantees this for Clk ≤ 100 MHz.

## Configuration
- ADC_AVERAGE_EN defined: the accumulator and AvgShift averaging are compiled in.
- ADC_AVERAGE_EN not defined:
  - AvgShift is ignored and the accumulator is not built.
  - Every capture after the PIPE_LAT discard is emitted as a raw word (identical to AvgShift=0).

## Test plan
- Raw, defaults, AdcStartDelay=2, AdcDataNumber=4, Hold held high:
  - first Data_en at edge 20, then at 24, 28, 32;
  - Done at 33; ADC_CLK 0 after 32.
- ADC_DATA=0xFFF with ADC_OTR=1 on one capture -> the corresponding Data=0x1FFF; the other words show bit 12 = 0.
- ADC_AVERAGE_EN, AvgShift=2, captures 100,101,102,103 -> a single Data_en with Data=101 (406>>2), OTR=0.
- AdcDataNumber=10, Hold falls after 3 raw words -> exactly 3 Data_en pulses, Done one cycle after Hold sync low, Busy=0 after.
- AdcDataNumber=0 -> Busy for AdcStartDelay+1 cycles, Done pulse, no ADC_CLK edges, no Data_en.
- Control and reset corner cases:
  - StartAcq=0 with a Hold pulse -> stays in IDLE.
  - reset_n low mid-RUN -> all outputs 0 immediately, no Done.
